// File: rtl/pixel_bank_pingpong_ctrl.sv
// pixel_bank_pingpong_ctrl
//   Ping-pong controller for a two-position, four-lane pixel vector bank.
//   Runs one frame of num_vec vectors. The producer writes into the free
//   position while the consumer reads the filled one, so the bank behaves
//   as a 2-entry FIFO.
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   start, num_vec           frame start (IDLE only) and vector count
//   busy, done               state != IDLE, one-cycle end-of-frame pulse
//   in_valid, in_ready       producer handshake
//   in_d1..in_d4             producer lanes
//   out_valid, out_ready     consumer handshake (data comes from the bank)
//   bank_we, bank_wr_pos     bank write enable / position
//   bank_rd_pos              bank read position (held between frames)
//   bank_wd1..bank_wd4       bank write data
module pixel_bank_pingpong_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_d1,
  input  logic [DATA_W-1:0] in_d2,
  input  logic [DATA_W-1:0] in_d3,
  input  logic [DATA_W-1:0] in_d4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              bank_we,
  output logic              bank_wr_pos,
  output logic              bank_rd_pos,
  output logic [DATA_W-1:0] bank_wd1,
  output logic [DATA_W-1:0] bank_wd2,
  output logic [DATA_W-1:0] bank_wd3,
  output logic [DATA_W-1:0] bank_wd4
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]       full_q, full_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;

  logic run;
  logic wr_fire;
  logic rd_fire;

  assign run = (state_q == S_RUN);

  // in_ready looks only at registered full[], so a slot freed by a read this
  // cycle is not reused until the next one (no out_ready -> in_ready path).
  assign in_ready  = run && !full_q[wr_ptr_q] && (wr_cnt_q < n_q);
  assign out_valid = run && full_q[rd_ptr_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign bank_we     = wr_fire;
  assign bank_wr_pos = wr_ptr_q;
  assign bank_rd_pos = rd_ptr_q;

  // Lanes pass straight through while a frame runs; held at zero otherwise
  // so every output is quiet outside a frame.
  assign bank_wd1 = run ? in_d1 : '0;
  assign bank_wd2 = run ? in_d2 : '0;
  assign bank_wd3 = run ? in_d3 : '0;
  assign bank_wd4 = run ? in_d4 : '0;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d      = num_vec;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          full_d   = '0;
          wr_ptr_d = 1'b0;
          rd_ptr_d = 1'b0;
          state_d  = (num_vec == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Write and read always hit different slots: write needs an empty
        // one, read a full one.
        if (wr_fire) begin
          full_d[wr_ptr_q] = 1'b1;
          wr_ptr_d         = ~wr_ptr_q;
          wr_cnt_d         = wr_cnt_q + CNT_W'(1);
        end
        if (rd_fire) begin
          full_d[rd_ptr_q] = 1'b0;
          rd_ptr_d         = ~rd_ptr_q;
          rd_cnt_d         = rd_cnt_q + CNT_W'(1);
          if (rd_cnt_d == n_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_pixel_bank_pingpong_ctrl.sv
// Directed bench for pixel_bank_pingpong_ctrl with a small two-position
// bank model standing in for the real pixel bank.
module tb_pixel_bank_pingpong_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic        busy, done;
  logic        in_valid, in_ready;
  logic [31:0] in_d1, in_d2, in_d3, in_d4;
  logic        out_valid, out_ready;
  logic        bank_we, bank_wr_pos, bank_rd_pos;
  logic [31:0] bank_wd1, bank_wd2, bank_wd3, bank_wd4;

  int checks;
  int failures;

  pixel_bank_pingpong_ctrl #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3), .in_d4(in_d4),
    .out_valid(out_valid), .out_ready(out_ready),
    .bank_we(bank_we), .bank_wr_pos(bank_wr_pos), .bank_rd_pos(bank_rd_pos),
    .bank_wd1(bank_wd1), .bank_wd2(bank_wd2), .bank_wd3(bank_wd3), .bank_wd4(bank_wd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: write on bank_we, combinational read at bank_rd_pos.
  logic [31:0] bank_m [0:1][0:3];
  always @(posedge clk) begin
    if (bank_we) begin
      bank_m[bank_wr_pos][0] <= bank_wd1;
      bank_m[bank_wr_pos][1] <= bank_wd2;
      bank_m[bank_wr_pos][2] <= bank_wd3;
      bank_m[bank_wr_pos][3] <= bank_wd4;
    end
  end
  logic [31:0] out1, out4;
  assign out1 = bank_m[bank_rd_pos][0];
  assign out4 = bank_m[bank_rd_pos][3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    in_d1 = a; in_d2 = b; in_d3 = c; in_d4 = d;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; start = 1'b1; out_ready = 1'b1; num_vec = 16'd3;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (bank_we !== 1'b0) begin failures++; $display("FAIL reset_bank_we got=%0b exp=0", bank_we); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (bank_rd_pos !== 1'b0 || bank_wr_pos !== 1'b0) begin failures++; $display("FAIL reset_pos got=%0b%0b exp=00", bank_wr_pos, bank_rd_pos); end
    rst = 1'b1; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
    tick();
  endtask

  task automatic test_fill_two();
    start = 1'b1; num_vec = 16'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1; set_data(32'd15, 32'd45, 32'd74, 32'd82);
    #1;
    checks++; if (bank_we !== 1'b1 || bank_wr_pos !== 1'b0) begin failures++; $display("FAIL fill_we0 got=we%0b pos%0b exp=we1 pos0", bank_we, bank_wr_pos); end
    checks++; if ({bank_wd1, bank_wd2, bank_wd3, bank_wd4} !== {32'd15, 32'd45, 32'd74, 32'd82}) begin failures++; $display("FAIL fill_wd0 got=%0d,%0d,%0d,%0d exp=15,45,74,82", bank_wd1, bank_wd2, bank_wd3, bank_wd4); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_ov_early got=%0b exp=0", out_valid); end
    tick();
    set_data(32'd16, 32'd46, 32'd75, 32'd83);
    #1;
    checks++; if (bank_we !== 1'b1 || bank_wr_pos !== 1'b1) begin failures++; $display("FAIL fill_we1 got=we%0b pos%0b exp=we1 pos1", bank_we, bank_wr_pos); end
    checks++; if (bank_wd1 !== 32'd16 || bank_wd4 !== 32'd83) begin failures++; $display("FAIL fill_wd1 got=%0d,%0d exp=16,83", bank_wd1, bank_wd4); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_latency got=%0b exp=1", out_valid); end
    tick();
    #1;
    checks++; if (in_ready !== 1'b0 || bank_we !== 1'b0) begin failures++; $display("FAIL fill_holdoff got=rdy%0b we%0b exp=rdy0 we0", in_ready, bank_we); end
    checks++; if (out_valid !== 1'b1 || bank_rd_pos !== 1'b0) begin failures++; $display("FAIL fill_rd got=ov%0b pos%0b exp=ov1 pos0", out_valid, bank_rd_pos); end
    checks++; if (out1 !== 32'd15 || out4 !== 32'd82) begin failures++; $display("FAIL fill_out got=%0d,%0d exp=15,82", out1, out4); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (bank_rd_pos !== 1'b1 || out1 !== 32'd16 || out_valid !== 1'b1) begin failures++; $display("FAIL fill_rd2 got=pos%0b out1=%0d ov%0b exp=pos1 out1=16 ov1", bank_rd_pos, out1, out_valid); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL fill_done got=done%0b busy%0b ov%0b exp=110", done, busy, out_valid); end
    out_ready = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL fill_idle got=done%0b busy%0b exp=00", done, busy); end
  endtask

  task automatic test_streaming();
    logic exp_we, exp_rd, exp_pos;
    start = 1'b1; num_vec = 16'd8;
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      set_data(32'(c * 256 + 1), 32'(c * 256 + 2), 32'(c * 256 + 3), 32'(c * 256 + 4));
      #1;
      exp_we = (c < 8);
      exp_rd = (c >= 1) && (c <= 8);
      checks++; if (bank_we !== exp_we) begin failures++; $display("FAIL stream_we c=%0d got=%0b exp=%0b", c, bank_we, exp_we); end
      if (exp_we) begin
        exp_pos = 1'(c % 2);
        checks++; if (bank_wr_pos !== exp_pos) begin failures++; $display("FAIL stream_wr_pos c=%0d got=%0b exp=%0b", c, bank_wr_pos, exp_pos); end
      end
      checks++; if ((out_valid && out_ready) !== exp_rd) begin failures++; $display("FAIL stream_rd c=%0d got=%0b exp=%0b", c, out_valid, exp_rd); end
      if (exp_rd) begin
        exp_pos = 1'((c - 1) % 2);
        checks++; if (bank_rd_pos !== exp_pos || out1 !== 32'((c - 1) * 256 + 1)) begin failures++; $display("FAIL stream_rd_data c=%0d got=pos%0b out1=%0h exp=pos%0b out1=%0h", c, bank_rd_pos, out1, exp_pos, (c - 1) * 256 + 1); end
      end
      checks++; if (done !== (c == 9)) begin failures++; $display("FAIL stream_done c=%0d got=%0b exp=%0b", c, done, (c == 9)); end
      checks++; if (busy !== (c <= 9)) begin failures++; $display("FAIL stream_busy c=%0d got=%0b exp=%0b", c, busy, (c <= 9)); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_read_pulse();
    int dones;
    start = 1'b1; num_vec = 16'd4;
    tick();
    start = 1'b0; in_valid = 1'b1;
    set_data(32'd21, 32'd22, 32'd23, 32'd24);
    tick();
    set_data(32'd31, 32'd32, 32'd33, 32'd34);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || bank_rd_pos !== 1'b0 || out1 !== 32'd21) begin failures++; $display("FAIL pulse_full got=rdy%0b pos%0b out1=%0d exp=rdy0 pos0 out1=21", in_ready, bank_rd_pos, out1); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (bank_rd_pos !== 1'b1 || out1 !== 32'd31) begin failures++; $display("FAIL pulse_rd_pos got=%0b out1=%0d exp=1 out1=31", bank_rd_pos, out1); end
    checks++; if (in_ready !== 1'b1 || bank_wr_pos !== 1'b0) begin failures++; $display("FAIL pulse_in_ready got=rdy%0b pos%0b exp=rdy1 pos0", in_ready, bank_wr_pos); end
    checks++; if (bank_we !== 1'b0) begin failures++; $display("FAIL pulse_no_we got=%0b exp=0", bank_we); end
    tick();
    checks++; if (bank_we !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL pulse_no_we2 got=we%0b rdy%0b exp=we0 rdy1", bank_we, in_ready); end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      if (done) dones++;
      checks++; if (done !== (i == 3)) begin failures++; $display("FAIL pulse_drain_done i=%0d got=%0b exp=%0b", i, done, (i == 3)); end
      tick();
    end
    checks++; if (dones !== 1 || busy !== 1'b0) begin failures++; $display("FAIL pulse_end got=dones%0d busy%0b exp=dones1 busy0", dones, busy); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_zero_frame();
    start = 1'b1; num_vec = 16'd0;
    #1;
    checks++; if (done !== 1'b0 || bank_we !== 1'b0) begin failures++; $display("FAIL zero_pre got=done%0b we%0b exp=00", done, bank_we); end
    tick();
    start = 1'b0; in_valid = 1'b1;
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL zero_done got=done%0b busy%0b exp=11", done, busy); end
    checks++; if (bank_we !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL zero_quiet got=we%0b ov%0b rdy%0b exp=000", bank_we, out_valid, in_ready); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || bank_we !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL zero_after got=done%0b busy%0b we%0b ov%0b exp=0000", done, busy, bank_we, out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    start = 1'b1; num_vec = 16'd5;
    tick();
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_data(32'(100 + i), 32'd0, 32'd0, 32'd0);
      #1;
      checks++; if (bank_we !== 1'b1) begin failures++; $display("FAIL mid_write i=%0d got=%0b exp=1", i, bank_we); end
      tick();
    end
    rst = 1'b0;
    tick();
    checks++; if ({in_ready, out_valid, bank_we, busy, done, bank_wr_pos, bank_rd_pos} !== 7'b0) begin failures++; $display("FAIL mid_reset_outputs got=%b exp=0000000", {in_ready, out_valid, bank_we, busy, done, bank_wr_pos, bank_rd_pos}); end
    checks++; if (bank_wd1 !== 32'd0) begin failures++; $display("FAIL mid_reset_wd got=%0d exp=0", bank_wd1); end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_no_done got=done%0b busy%0b exp=00", done, busy); end
    start = 1'b1; num_vec = 16'd2;
    tick();
    start = 1'b0; in_valid = 1'b1;
    set_data(32'd777, 32'd1, 32'd2, 32'd3);
    #1;
    checks++; if (bank_we !== 1'b1 || bank_wr_pos !== 1'b0) begin failures++; $display("FAIL mid_restart_wr got=we%0b pos%0b exp=we1 pos0", bank_we, bank_wr_pos); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || bank_rd_pos !== 1'b0 || out1 !== 32'd777) begin failures++; $display("FAIL mid_restart_rd got=ov%0b pos%0b out1=%0d exp=ov1 pos0 out1=777", out_valid, bank_rd_pos, out1); end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      if (done) dones++;
      tick();
    end
    checks++; if (dones !== 1 || busy !== 1'b0) begin failures++; $display("FAIL mid_restart_end got=dones%0d busy%0b exp=dones1 busy0", dones, busy); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; start = 1'b0; num_vec = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    set_data('0, '0, '0, '0);
    test_reset();
    test_fill_two();
    test_streaming();
    test_read_pulse();
    test_zero_frame();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
